// File: rtl/video_fb_arbiter_pkg.sv
// Shared constants, typedefs and FSM encoding for the framebuffer arbiter.
package video_fb_arbiter_pkg;

  localparam int FB_DOTCLK_DIV  = 10;
  localparam int FB_H_ACTIVE    = 240;
  localparam int FB_V_ACTIVE    = 320;
  localparam int FB_H_BITS      = 9;
  localparam int FB_V_BITS      = 9;
  localparam int FB_PIX_BITS    = 16;
  localparam int FB_RAM_LATENCY = 2;
  localparam int FB_ADDR_BITS   = $clog2(FB_H_ACTIVE * FB_V_ACTIVE);

  typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;
  typedef logic [FB_PIX_BITS-1:0]  pixel_t;

  // Scan-out read sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } fb_state_e;

endpackage

// File: rtl/video_fb_arbiter_if.sv
// Writer-side request/grant bus into the framebuffer arbiter.
interface video_fb_arbiter_if
  import video_fb_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = FB_ADDR_BITS,
  parameter int PIX_BITS  = FB_PIX_BITS
);

  logic                 wr_valid;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [PIX_BITS-1:0]  wr_data;
  logic                 wr_ready;

  // Writer (CPU / draw engine) side.
  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  // Arbiter side.
  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/video_fb_arbiter_fb_addr_gen.sv
// Linear framebuffer address from the active-region position: v * stride + h.
// The product is formed at address width, so excess high bits are dropped.
module fb_addr_gen #(
  parameter int H_ACTIVE  = 240,
  parameter int H_BITS    = 9,
  parameter int V_BITS    = 9,
  parameter int ADDR_BITS = 17
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [H_BITS-1:0]    pos_h,
  input  logic [V_BITS-1:0]    pos_v,
  output logic [ADDR_BITS-1:0] addr
);

  logic [ADDR_BITS-1:0] addr_d;
  logic [ADDR_BITS-1:0] addr_q;

  // Unsigned multiply-add, zero-extended operands, truncated to address width.
  always_comb begin
    addr_d = ADDR_BITS'(pos_v) * ADDR_BITS'(H_ACTIVE) + ADDR_BITS'(pos_h);
  end

  // Capture the address of the pixel whose read is being issued.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/video_fb_arbiter.sv
// Shares a single-port framebuffer RAM between pixel scan-out and one writer.
// Each active dot issues one read on the cycle after the dotclk rising edge;
// the writer is granted every cycle except that edge cycle.
module video_fb_arbiter
  import video_fb_arbiter_pkg::*;
#(
  parameter int H_ACTIVE    = FB_H_ACTIVE,
  parameter int V_ACTIVE    = FB_V_ACTIVE,
  parameter int H_BITS      = FB_H_BITS,
  parameter int V_BITS      = FB_V_BITS,
  parameter int PIX_BITS    = FB_PIX_BITS,
  parameter int RAM_LATENCY = FB_RAM_LATENCY,
  parameter int ADDR_BITS   = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dotclk,
  input  logic                 active,
  input  logic [H_BITS-1:0]    pos_h,
  input  logic [V_BITS-1:0]    pos_v,
  output logic [PIX_BITS-1:0]  pix_data,
  output logic                 pix_valid,
  video_fb_arbiter_if.slave    wr_if,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [PIX_BITS-1:0]  ram_wdata,
  input  logic [PIX_BITS-1:0]  ram_rdata
);

  // S_WAIT spans RAM_LATENCY-1 cycles; with a 1-cycle RAM it is skipped.
  localparam int              CNT_W     = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RAM_LATENCY > 2) ? RAM_LATENCY - 2 : 0);
  localparam bit              SKIP_WAIT = (RAM_LATENCY == 1);

  logic                 dotclk_d, dotclk_q;
  logic                 pix_edge;
  logic                 rd_start;
  logic                 wr_ready;
  logic                 wr_fire;

  fb_state_e            state_d, state_q;
  logic [CNT_W-1:0]     wait_cnt_d, wait_cnt_q;
  logic [PIX_BITS-1:0]  pix_data_d, pix_data_q;
  logic                 pix_valid_d, pix_valid_q;

  logic                 ram_en_d, ram_en_q;
  logic                 ram_we_d, ram_we_q;
  logic                 sel_rd_d, sel_rd_q;
  logic [ADDR_BITS-1:0] ram_waddr_d, ram_waddr_q;
  logic [PIX_BITS-1:0]  ram_wdata_d, ram_wdata_q;
  logic [ADDR_BITS-1:0] rd_addr;

  // The read address register lives in the address generator; it is loaded
  // in the same cycle the read strobe register is, so both appear together.
  fb_addr_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .H_BITS    (H_BITS),
    .V_BITS    (V_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk   (clk),
    .load  (rd_start),
    .pos_h (pos_h),
    .pos_v (pos_v),
    .addr  (rd_addr)
  );

  // Edge detect and write grant: the video read owns the edge cycle.
  always_comb begin
    dotclk_d = dotclk;
    pix_edge = dotclk && !dotclk_q;
    rd_start = pix_edge && active;
    wr_ready = !rst && !rd_start;
    wr_fire  = wr_if.wr_valid && wr_ready;
  end

  assign wr_if.wr_ready = wr_ready;

  // RAM command mux: at most one of read or write per cycle; address and
  // write data hold their last value on idle cycles.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    sel_rd_d    = sel_rd_q;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    if (rd_start) begin
      ram_en_d = 1'b1;
      sel_rd_d = 1'b1;
    end else if (wr_fire) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      sel_rd_d    = 1'b0;
      ram_waddr_d = wr_if.wr_addr;
      ram_wdata_d = wr_if.wr_data;
    end
  end

  // Read sequencer: a new dot edge always restarts it, abandoning any read
  // still in flight; a blank dot clears the panel output immediately.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    if (pix_edge) begin
      if (active) begin
        state_d = S_ISSUE;
      end else begin
        state_d     = S_IDLE;
        pix_data_d  = '0;
        pix_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          wait_cnt_d = '0;
          state_d    = SKIP_WAIT ? S_LATCH : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = S_LATCH;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        S_LATCH: begin
          pix_data_d  = ram_rdata;
          pix_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, RAM command and panel output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dotclk_q    <= 1'b1;
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      sel_rd_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      dotclk_q    <= dotclk_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      sel_rd_q    <= sel_rd_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = sel_rd_q ? rd_addr : ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_video_fb_arbiter.sv
// Bench for video_fb_arbiter: a pipelined RAM model plus a reference
// framebuffer image updated from accepted writes; each active dot must show
// the image value at v*240+h as it stood when the dot edge arrived.
module tb_video_fb_arbiter;
  import video_fb_arbiter_pkg::*;

  localparam int HA   = 240;
  localparam int AB   = FB_ADDR_BITS;
  localparam int PB   = FB_PIX_BITS;
  localparam int MEMN = 1 << AB;

  logic          clk = 1'b0;
  logic          rst;
  logic          dotclk;
  logic          active;
  logic [8:0]    pos_h;
  logic [8:0]    pos_v;
  logic [PB-1:0] pix_data;
  logic          pix_valid;
  logic          ram_en;
  logic          ram_we;
  logic [AB-1:0] ram_addr;
  logic [PB-1:0] ram_wdata;
  logic [PB-1:0] ram_rdata;

  always #5 clk = ~clk;

  video_fb_arbiter_if #(.ADDR_BITS(AB), .PIX_BITS(PB)) wr_if ();

  video_fb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .dotclk    (dotclk),
    .active    (active),
    .pos_h     (pos_h),
    .pos_v     (pos_v),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .wr_if     (wr_if),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port RAM, two-cycle pipelined read; non-read cycles return junk.
  logic [PB-1:0] mem [MEMN];
  logic [PB-1:0] rd_stage;
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    rd_stage  <= (ram_en && !ram_we) ? mem[ram_addr] : 16'hDEAD;
    ram_rdata <= rd_stage;
  end

  logic [PB-1:0] ref_mem [MEMN];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [PB-1:0] prev_pix;
  logic          prev_vld;
  bit            wr_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full dot period (10 clk: dotclk high 5, low 5) with an optional writer.
  task automatic run_dot(input bit act, input int h, input int v, input int wr_pct,
                         input int tgt, output int nacc);
    int            exp_addr;
    logic [PB-1:0] exp_pix;
    logic [AB-1:0] wa;
    logic [PB-1:0] wd;
    bit            acc;
    nacc     = 0;
    exp_addr = (v * HA + h) % MEMN;
    exp_pix  = '0;
    wa       = '0;
    wd       = '0;
    for (int c = 0; c < 10; c++) begin
      dotclk = (c < 5);
      active = act;
      pos_h  = 9'(h);
      pos_v  = 9'(v);
      if (wr_done) begin
        wr_if.wr_valid = 1'b0;
        wr_done        = 1'b0;
      end
      if (!wr_if.wr_valid && ($urandom_range(99) < wr_pct)) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = ($urandom_range(3) == 0) ? AB'($urandom) : AB'(tgt);
        wr_if.wr_data  = PB'($urandom);
      end
      #1;
      check("wr_ready", wr_if.wr_ready, (c == 0 && act) ? 0 : 1);
      if (c == 0 && act) exp_pix = ref_mem[exp_addr];
      acc = wr_if.wr_valid && wr_if.wr_ready;
      if (acc) begin
        ref_mem[wr_if.wr_addr] = wr_if.wr_data;
        wa      = wr_if.wr_addr;
        wd      = wr_if.wr_data;
        wr_done = 1'b1;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        check("wr_en", ram_en, 1);
        check("wr_we", ram_we, 1);
        check("wr_addr", ram_addr, wa);
        check("wr_wdata", ram_wdata, wd);
      end else if (c == 0 && act) begin
        check("rd_en", ram_en, 1);
        check("rd_we", ram_we, 0);
        check("rd_addr", ram_addr, exp_addr);
      end else begin
        check("idle_en", ram_en, 0);
        check("idle_we", ram_we, 0);
      end
      if (c == 0 && !act) begin
        check("blank_valid", pix_valid, 0);
        check("blank_data", pix_data, 0);
      end
      if (c == 2 && act) begin
        check("early_data", pix_data, prev_pix);
        check("early_valid", pix_valid, prev_vld);
      end
      if (c == 3 || c == 8) begin
        check("pix_data", pix_data, act ? exp_pix : '0);
        check("pix_valid", pix_valid, act);
      end
    end
    prev_pix = act ? exp_pix : '0;
    prev_vld = act;
  endtask

  initial begin
    int nacc;
    int h, v, nh, nv;
    bit act;
    for (int a = 0; a < MEMN; a++) begin
      mem[a]     = PB'(a);
      ref_mem[a] = PB'(a);
    end
    prev_pix = '0;
    prev_vld = 1'b0;
    wr_done  = 1'b0;

    // Reset with a writer already requesting.
    rst            = 1'b1;
    dotclk         = 1'b0;
    active         = 1'b0;
    pos_h          = '0;
    pos_v          = '0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst_ram_en", ram_en, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_wr_ready", wr_if.wr_ready, 0);
    end
    rst            = 1'b0;
    wr_if.wr_valid = 1'b0;
    #1;
    check("wr_ready_after_rst", wr_if.wr_ready, 1);
    @(posedge clk);
    #1;

    // Scan-out of (5,3).
    run_dot(1'b1, 5, 3, 0, 0, nacc);
    check("scan_725", pix_data, 725);
    check("scan_valid", pix_valid, 1);

    // Frame wrap: last pixel then first pixel.
    run_dot(1'b1, 239, 319, 0, 0, nacc);
    check("wrap_last", pix_data, 16'h2BFF);
    run_dot(1'b1, 0, 0, 0, 0, nacc);
    check("wrap_first", pix_data, 0);
    check("wrap_first_valid", pix_valid, 1);

    // Coherency: write 0xBEEF to address 10, then read pixel (10,0).
    wr_done        = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = AB'(10);
    wr_if.wr_data  = 16'hBEEF;
    run_dot(1'b0, 0, 0, 0, 0, nacc);
    check("coh_wr_accepted", nacc, 1);
    run_dot(1'b1, 10, 0, 0, 0, nacc);
    check("coh_beef", pix_data, 16'hBEEF);

    // Collision: writer continuously requesting across an active edge,
    // mostly to the very pixel being read.
    run_dot(1'b1, 20, 7, 100, 7 * HA + 20, nacc);
    check("coll_wr_cnt", nacc, 9);

    // Blanking dot with a back-to-back writer.
    run_dot(1'b0, 100, 100, 100, 100 * HA + 100, nacc);
    check("blank_wr_cnt", (nacc >= 9), 1);
    run_dot(1'b0, 101, 100, 0, 0, nacc);

    // Reset one clk after the read issue: nothing may be latched.
    wr_if.wr_valid = 1'b0;
    wr_done        = 1'b0;
    dotclk         = 1'b1;
    active         = 1'b1;
    pos_h          = 9'd7;
    pos_v          = 9'd2;
    @(posedge clk);
    #1;
    check("mr_issue_en", ram_en, 1);
    check("mr_issue_addr", ram_addr, 487);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 3; c < 10; c++) begin
      dotclk = (c < 5);
      check("mr_pix_valid", pix_valid, 0);
      check("mr_pix_data", pix_data, 0);
      @(posedge clk);
      #1;
    end
    check("mr_end_valid", pix_valid, 0);
    prev_pix = '0;
    prev_vld = 1'b0;

    // Randomized dots; writes usually target the next pixel to be shown.
    nh = $urandom_range(HA - 1);
    nv = $urandom_range(319);
    for (int i = 0; i < 40; i++) begin
      h   = nh;
      v   = nv;
      act = ($urandom_range(3) != 0);
      nh  = $urandom_range(HA - 1);
      nv  = $urandom_range(319);
      run_dot(act, h, v, 50, nv * HA + nh, nacc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
